// File: rtl/fetch_seq.sv
// fetch_seq: owns the program counter, sequences ROM reads, presents opcodes
// downstream with valid/ready and applies branch/call/return redirects.
// Optional build macro FETCH_HALT_EN: the all-ones opcode halts fetching.
module fetch_seq #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] op_out,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              br_req,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] br_target,
  output logic              stk_err
`ifdef FETCH_HALT_EN
  ,
  output logic              halted
`endif
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned SP_W  = $clog2(STK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STK_DEPTH);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
`endif

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d, addr_d, pco_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   op_d;
  logic                vld_d, err_d;
  logic [SP_W-1:0]     sp;
  logic [ADDR_W-1:0]   stk [STK_DEPTH];
  logic                push, pop;
  logic [ADDR_W-1:0]   pc_inc, top;
  logic                empty, full;
`ifdef FETCH_HALT_EN
  logic                halt_d;
`endif

  assign pc_inc = pc_out + ADDR_W'(1);
  assign top    = stk[IDX_W'(sp - SP_W'(1))];
  assign empty  = (sp == '0);
  assign full   = (sp == SP_W'(STK_DEPTH));

  // Read strobe only in FETCH; disable and reset mask it immediately
  assign rom_rd = rst_n & en & (state == FETCH);

  // Next-state, datapath and stack-operation decode
  always_comb begin
    state_d = state;
    pc_d    = pc;
    addr_d  = rom_addr;
    cnt_d   = cnt;
    op_d    = op_out;
    pco_d   = pc_out;
    vld_d   = op_valid;
    err_d   = stk_err;
    push    = 1'b0;
    pop     = 1'b0;
`ifdef FETCH_HALT_EN
    halt_d  = halted;
`endif
    case (state)
      FETCH: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(ROM_LAT);
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          op_d    = rom_data;
          pco_d   = pc;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (op_ready) begin
          vld_d   = 1'b0;
          state_d = FETCH;
          pc_d    = pc_inc;
          if (ret_req) begin
            if (!empty) begin
              pc_d = top;
              pop  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (call_req) begin
            pc_d = br_target;
            if (!full) push = 1'b1;
            else       err_d = 1'b1;
          end else if (br_req) begin
            pc_d = br_target;
          end
          addr_d = pc_d;
`ifdef FETCH_HALT_EN
          if (op_out == '1) begin
            state_d = HALT;
            halt_d  = 1'b1;
            pc_d    = pc;
            addr_d  = rom_addr;
            err_d   = stk_err;
            push    = 1'b0;
            pop     = 1'b0;
          end
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= FETCH;
    else if (en) state <= state_d;
  end

  // Datapath registers; en low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      rom_addr <= '0;
      cnt      <= '0;
      op_out   <= '0;
      pc_out   <= '0;
      op_valid <= 1'b0;
      stk_err  <= 1'b0;
`ifdef FETCH_HALT_EN
      halted   <= 1'b0;
`endif
    end else if (en) begin
      pc       <= pc_d;
      rom_addr <= addr_d;
      cnt      <= cnt_d;
      op_out   <= op_d;
      pc_out   <= pco_d;
      op_valid <= vld_d;
      stk_err  <= err_d;
`ifdef FETCH_HALT_EN
      halted   <= halt_d;
`endif
    end
  end

  // Return stack: push the return address or pop the top entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < STK_DEPTH; i++) stk[i] <= '0;
    end else if (en) begin
      if (push) begin
        stk[IDX_W'(sp)] <= pc_inc;
        sp              <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: table-driven redirect sequence with an expected-PC scoreboard,
// plus hand-written timing, stall, reset, enable and halt sequences.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, op_ready, br_req, call_req, ret_req, rom_rd, op_valid, stk_err;
  logic [7:0]  rom_addr, pc_out, br_target;
  logic [15:0] rom_data, op_out;
`ifdef FETCH_HALT_EN
  logic        halted, halted2;
`endif

  logic        rst2_n, en2, rdy2, rd2, vld2, err2;
  logic [7:0]  addr2, pco2;
  logic [15:0] data2, op2;
  logic        zero_b = 1'b0;
  logic [7:0]  zero_t = 8'h00;

  logic [15:0] rom [256];
  logic [15:0] rd1, p0, p1, p2;

  typedef struct {
    logic       br;
    logic       call;
    logic       ret;
    logic [7:0] tgt;
    logic [7:0] nxt;
    logic       err;
  } vec_t;

  vec_t       vec [24];
  int         nv = 0;
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fetch_seq #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(1), .STK_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rom_data), .op_out(op_out), .op_valid(op_valid), .op_ready(op_ready),
    .pc_out(pc_out), .br_req(br_req), .call_req(call_req), .ret_req(ret_req),
    .br_target(br_target), .stk_err(stk_err)
`ifdef FETCH_HALT_EN
    , .halted(halted)
`endif
  );

  fetch_seq #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(3), .STK_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .rom_addr(addr2), .rom_rd(rd2),
    .rom_data(data2), .op_out(op2), .op_valid(vld2), .op_ready(rdy2),
    .pc_out(pco2), .br_req(zero_b), .call_req(zero_b), .ret_req(zero_b),
    .br_target(zero_t), .stk_err(err2)
`ifdef FETCH_HALT_EN
    , .halted(halted2)
`endif
  );

  // One-cycle ROM for the main instance
  always @(posedge clk) if (rom_rd) rd1 <= rom[rom_addr];
  assign rom_data = rd1;

  // Three-cycle ROM pipeline, held while en2 is low
  always @(posedge clk) begin
    if (en2) begin
      if (rd2) p0 <= rom[addr2];
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign data2 = p2;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic b, input logic c, input logic r,
                     input logic [7:0] t, input logic [7:0] n, input logic e);
    vec[nv] = '{b, c, r, t, n, e};
    nv++;
  endtask

  task automatic noise();
    br_req = 1'b1; call_req = 1'b1; ret_req = 1'b1; br_target = 8'hEE;
  endtask

  // Wait for the next presented opcode and compare it against the scoreboard
  task automatic arrive();
    int n = 0;
    logic [7:0] e;
    while (!op_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!op_valid) begin
      errors++;
      $display("FAIL arrive_timeout actual=0 required=1");
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty actual=%0h required=none", pc_out);
    end else begin
      e = sb.pop_front();
      chk("pc_out", 32'(pc_out), 32'(e));
      chk("op_out", 32'(op_out), 32'(rom[e]));
    end
  endtask

  // Handshake the held opcode with the given redirect and queue the next PC
  task automatic take(input logic b, input logic c, input logic r,
                      input logic [7:0] t, input logic [7:0] n, input logic e);
    br_req = b; call_req = c; ret_req = r; br_target = t; op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    noise();
    sb.push_back(n);
    chk("stk_err", 32'(stk_err), 32'(e));
    chk("fetch_addr", 32'(rom_addr), 32'(n));
    chk("fetch_rd", 32'(rom_rd), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int cyc, k;
    bit bad;
    for (int i = 0; i < 256; i++) rom[i] = 16'hA500 | 16'(i);
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    rom[7] = 16'hFFFF;

    add(0,0,0,8'h00,8'h03,0); add(0,0,0,8'h00,8'h04,0); add(0,0,0,8'h00,8'h05,0);
    add(0,1,0,8'h40,8'h40,0); add(0,0,0,8'h00,8'h41,0); add(0,0,0,8'h00,8'h42,0);
    add(0,0,1,8'h00,8'h06,0); add(1,0,0,8'h20,8'h20,0); add(0,1,0,8'h50,8'h50,0);
    add(1,1,1,8'h70,8'h21,0); add(0,1,0,8'h60,8'h60,0); add(0,1,0,8'h62,8'h62,0);
    add(0,1,0,8'h64,8'h64,0); add(0,1,0,8'h66,8'h66,0); add(0,1,0,8'h68,8'h68,1);
    add(0,0,1,8'h00,8'h65,1); add(0,0,1,8'h00,8'h63,1); add(0,0,1,8'h00,8'h61,1);
    add(0,0,1,8'h00,8'h22,1); add(1,0,0,8'h10,8'h10,1); add(0,0,1,8'h00,8'h11,1);
    add(1,0,0,8'hFE,8'hFE,1); add(0,0,0,8'h00,8'hFF,1); add(0,0,0,8'h00,8'h00,1);

    rst_n = 1'b0; en = 1'b1; op_ready = 1'b0;
    br_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; br_target = 8'h00;
    rst2_n = 1'b0; en2 = 1'b1; rdy2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_out", 32'(op_out), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_stk_err", 32'(stk_err), 32'd0);
`ifdef FETCH_HALT_EN
    chk("rst_halted", 32'(halted), 32'd0);
`endif

    // Free-running stream: first valid 2 cycles after release, then every 3
    op_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(8'(i));
    @(negedge clk) rst_n = 1'b1;
    cyc = 0; k = 0;
    repeat (12) begin
      @(posedge clk); #1; cyc++;
      if (op_valid && k < 4) begin
        chk("stream_cycle", 32'(cyc), 32'(2 + 3 * k));
        chk("stream_pc", 32'(pc_out), 32'(sb[0]));
        chk("stream_op", 32'(op_out), 32'(rom[sb[0]]));
        void'(sb.pop_front());
        k++;
      end
    end
    chk("stream_count", 32'(k), 32'd4);
    op_ready = 1'b0;

    // Stall on 0x2222 for five cycles, then release
    sb.delete();
    noise();
    do_reset();
    sb.push_back(8'h00);
    arrive();
    take(0,0,0,8'h00,8'h01,0);
    arrive();
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!op_valid || rom_rd || op_out !== 16'h2222 || pc_out !== 8'h01) bad = 1'b1;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    take(0,0,0,8'h00,8'h02,0);
    arrive();

    // Redirect table: branches, calls, returns, stack overflow/underflow, wrap
    for (int i = 0; i < nv; i++) begin
      take(vec[i].br, vec[i].call, vec[i].ret, vec[i].tgt, vec[i].nxt, vec[i].err);
      arrive();
    end

    // Reset during WAIT drops everything; restart from address 0
    take(0,0,0,8'h00,8'h01,1);
    arrive();
    take(0,0,0,8'h00,8'h02,1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_op_valid", 32'(op_valid), 32'd0);
    chk("midrst_pc_out", 32'(pc_out), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_stk_err", 32'(stk_err), 32'd0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("restart_addr", 32'(rom_addr), 32'd0);
    chk("restart_rd", 32'(rom_rd), 32'd1);
    sb.push_back(8'h00);
    arrive();
    take(1,0,0,8'h07,8'h07,0);
    arrive();

`ifdef FETCH_HALT_EN
    br_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("halt_flag", 32'(halted), 32'd1);
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rom_rd || op_valid || !halted) bad = 1'b1;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
`else
    take(0,0,0,8'h00,8'h08,0);
    arrive();
`endif

    // Three-cycle ROM: latency 4 from FETCH, and en low pauses the count
    rdy2 = 1'b1;
    @(negedge clk) rst2_n = 1'b1;
    cyc = 0;
    while (!vld2 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("lat3_first", 32'(cyc), 32'd4);
    chk("lat3_pc", 32'(pco2), 32'd0);
    chk("lat3_op", 32'(op2), 32'h1111);
    @(posedge clk); #1;
    chk("lat3_fetch_rd", 32'(rd2), 32'd1);
    chk("lat3_fetch_addr", 32'(addr2), 32'd1);
    en2 = 1'b0; #1;
    chk("en_gates_rd", 32'(rd2), 32'd0);
    en2 = 1'b1; #1;
    @(posedge clk); #1;
    en2 = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (vld2 || rd2) bad = 1'b1;
    end
    chk("freeze_quiet", 32'(bad), 32'd0);
    en2 = 1'b1;
    cyc = 0;
    while (!vld2 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("freeze_delay", 32'(cyc), 32'd3);
    chk("freeze_pc", 32'(pco2), 32'd1);
    chk("freeze_op", 32'(op2), 32'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer for the Red core: owns the program counter, issues ROM reads, captures opcodes, presents them downstream with a valid/ready handshake.
- Applies branch, call and return redirects using a small hardware return stack.
- Sits between the program ROM and the decode/execute stage, replacing free-running PC increment with a sequenced, stallable fetch.

Parameters:
- ADDR_W, 8, PC and ROM address width.
- DATA_W, 16, opcode width.
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..7.
- STK_DEPTH, 4, return stack entries; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low freezes all state.
- rom_addr  output  ADDR_W  ROM read address.
- rom_rd  output  1  ROM read strobe.
- rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after the rom_rd edge.
- op_out  output  DATA_W  captured opcode.
- op_valid  output  1  op_out valid.
- op_ready  input  1  downstream accepts op_out.
- pc_out  output  ADDR_W  address of the opcode in op_out.
- br_req  input  1  jump to br_target; sampled at handshake.
- call_req  input  1  push pc_out+1, jump to br_target; sampled at handshake.
- ret_req  input  1  pop return stack, jump to the popped address; sampled at handshake.
- br_target  input  ADDR_W  redirect target.
- stk_err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values:
  - state=FETCH, pc=0, rom_addr=0, rom_rd=0, op_out=0, op_valid=0, pc_out=0.
  - stack pointer=0 (empty), stk_err=0, wait counter=0.
- Reset asserted mid-operation discards the in-flight read; the first fetch after release is from address 0.
- en=0: no register changes at all. Outputs hold their values; rom_rd is forced 0. The ROM_LAT count pauses. The bench must keep rom_data stable while en=0.
- FETCH (1 cycle): rom_addr=pc, rom_rd=1. Next state is WAIT with counter=ROM_LAT.
- WAIT: rom_rd=0, rom_addr held. Counter decrements each cycle. On the edge where counter=1:
  - op_out<=rom_data, pc_out<=pc, op_valid<=1.
  - next state is HOLD.
- HOLD: op_valid=1; op_out and pc_out stable until op_ready=1. On the handshake edge (op_valid&op_ready&en), op_valid<=0, the next pc is chosen by priority, and the next state is FETCH:
  - ret_req, stack non-empty: pc<=top of stack; pop.
  - ret_req, stack empty: pc<=pc_out+1; stk_err<=1.
  - call_req, stack not full: push pc_out+1; pc<=br_target.
  - call_req, stack full: no push; stk_err<=1; pc<=br_target (jump still taken).
  - br_req: pc<=br_target.
  - otherwise: pc<=pc_out+1.
- Redirect inputs are ignored outside the handshake edge.
- Arithmetic: pc_out+1 is modulo 2^ADDR_W, so address 2^ADDR_W-1 wraps to 0. Return addresses are stored ADDR_W wide.
- Timing: latency from entering FETCH to op_valid is ROM_LAT+1 cycles. Throughput with op_ready tied high is one opcode per ROM_LAT+2 cycles.
- stk_err clears only on reset.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined: an opcode of all ones (16'hFFFF at default width) is a halt.
  - It is still presented in HOLD as normal.
  - After its handshake the block enters HALT instead of FETCH: no rom_rd, op_valid=0, pc and stack frozen. Only rst_n leaves HALT.
  - Port halted output 1 is high in HALT (reset 0).
- Undefined: all-ones is an ordinary opcode; no HALT state; no halted port.

Test Plan:
- ROM[0..3]=1111,2222,3333,4444, ROM_LAT=1, op_ready=1 → op_out sequence 1111,2222,3333,4444 with pc_out 0,1,2,3. The first op_valid is 2 cycles after reset release, then one opcode every 3 cycles.
- op_ready=0 for 5 cycles while op 0x2222 is held → op_out/pc_out stable, rom_rd=0 throughout; next fetch address is 2 after ready.
- call_req at pc_out=5 with br_target=0x40, then ret_req at pc_out=0x42 → fetch sequence 5,0x40,0x41,0x42,6; stk_err=0.
- 5 nested calls with STK_DEPTH=4 → fifth call jumps to br_target and stk_err=1. A ret_req with an empty stack at pc_out=0x10 → next fetch 0x11, stk_err stays 1.
- Sequential fetch from pc=0xFF → next fetch address 0x00. rst_n pulsed low during WAIT → op_valid=0 immediately; next rom_addr=0.
- en=0 for 3 cycles in WAIT with ROM_LAT=3 → capture is delayed exactly 3 cycles. With FETCH_HALT_EN: opcode FFFF at pc 7 is accepted, then halted=1 and no further rom_rd.
